fetch_queue: RTL and testbench

- Instruction prefetch buffer between the instruction SRAM/PC stage and the fetch/decode pipeline register.
- Decouples fetch from decode.
- Captures {pc, inst, guess} triples from the fetch stage.
- Presents the oldest entry to decode in first-word-fall-through order.
- Drops all contents on a control-flow redirect (misprediction or jalr flush).

---
 rtl/fetch_queue_pkg.sv | 22 ++
 rtl/fetch_queue_mem.sv | 26 ++
 rtl/fetch_queue.sv | 87 ++++++++
 tb/tb_fetch_queue.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants for the instruction prefetch queue.
// This file holds the bubble encoding, the entry field widths and the packed entry layout.
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INST_ENC = 32'h0000_0013;  // addi x0,x0,0

  localparam int PC_W    = 32;
  localparam int INST_W  = 32;
  localparam int GUESS_W = 1;
  localparam int ENTRY_W = PC_W + INST_W + GUESS_W;

  localparam int GUESS_LSB = 0;
  localparam int INST_LSB  = GUESS_LSB + GUESS_W;
  localparam int PC_LSB    = INST_LSB + INST_W;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INST_W-1:0]  inst;
    logic [GUESS_W-1:0] guess;
  } entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Storage array for the prefetch queue.
// Writes are synchronous. Reads are combinational, so the head entry falls through to the outputs.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [PTR_W-1:0]   raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // NOTE: storage is deliberately left unreset; count gates visibility, so stale words never escape.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Prefetch buffer between instruction fetch and decode: FWFT FIFO of {pc, inst, guess}
// entries, emptied on redirect; presents a NOP bubble whenever it is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [31:0] NOP_INST = NOP_INST_ENC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      inst_in,
  input  logic             guess_in,
  input  logic             flush,
  input  logic             deq_stall,
  output logic             out_valid,
  output logic [31:0]      pc_out,
  output logic [31:0]      inst_out,
  output logic             guess_out,
  output logic [PTR_W:0]   count
);

  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               enq, deq;
  entry_t             wr_entry;
  logic [ENTRY_W-1:0] head;

  // in_ready looks only at registered count: a full queue never passes an entry through.
  assign in_ready  = (count_q < (PTR_W+1)'(DEPTH));
  assign out_valid = (count_q != '0);
  assign enq       = in_valid && in_ready && !flush;
  assign deq       = out_valid && !deq_stall && !flush;
  assign wr_entry  = '{pc: pc_in, inst: inst_in, guess: guess_in};

  fetch_queue_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk   (clk),
    .we    (enq),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count     = count_q;
  assign pc_out    = out_valid ? head[PC_LSB +: PC_W]       : '0;
  assign inst_out  = out_valid ? head[INST_LSB +: INST_W]   : NOP_INST;
  assign guess_out = out_valid ? head[GUESS_LSB]            : 1'b0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue. A queue model predicts occupancy and head order,
// and every DUT output is compared against that model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] pc_in = '0, inst_in = '0;
  logic        guess_in = 1'b0, flush = 1'b0, deq_stall = 1'b0;
  logic        out_valid, guess_out;
  logic [31:0] pc_out, inst_out;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;
  entry_t sb[$];

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(2), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .inst_in(inst_in), .guess_in(guess_in), .flush(flush),
    .deq_stall(deq_stall), .out_valid(out_valid), .pc_out(pc_out),
    .inst_out(inst_out), .guess_out(guess_out), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag);
    if (sb.size() > 0) begin
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_pc"},    64'(pc_out),    64'(sb[0].pc));
      check({tag, "_inst"},  64'(inst_out),  64'(sb[0].inst));
      check({tag, "_guess"}, 64'(guess_out), 64'(sb[0].guess));
    end else begin
      check({tag, "_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_pc"},    64'(pc_out),    64'd0);
      check({tag, "_inst"},  64'(inst_out),  64'h13);
      check({tag, "_guess"}, 64'(guess_out), 64'd0);
    end
  endtask

  task automatic check_count(input string tag);
    check({tag, "_count"}, 64'(count), 64'(sb.size()));
    check({tag, "_count_le_depth"}, 64'(count <= 3'(DEPTH)), 64'd1);
  endtask

  // One clock of traffic. The head is compared before the edge, and occupancy after it.
  task automatic step(input string tag, input logic v, input logic [31:0] pc,
                      input logic [31:0] inst, input logic fl, input logic stall);
    bit model_ready, do_enq, do_deq;
    entry_t e;
    in_valid = v; pc_in = pc; inst_in = inst; guess_in = pc[2];
    flush = fl; deq_stall = stall;
    model_ready = (sb.size() < DEPTH);
    do_enq = v && model_ready && !fl;
    do_deq = (sb.size() > 0) && !stall && !fl;
    check({tag, "_in_ready"}, 64'(in_ready), 64'(model_ready));
    check_head(tag);
    e = '{pc: pc, inst: inst, guess: pc[2]};
    @(posedge clk); #1;
    if (fl) sb.delete();
    else begin
      if (do_deq) void'(sb.pop_front());
      if (do_enq) sb.push_back(e);
    end
    in_valid = 1'b0; flush = 1'b0;
    check_count(tag);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    rst = 1'b1;
    check_count(tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check_head(tag);
  endtask

  initial begin
    // Reset and empty
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_inst", 64'(inst_out), 64'h13);
    check("rst_pc", 64'(pc_out), 64'd0);

    // Fill to full under stall, then offer a fifth entry that must be ignored
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 32'(i * 4), 32'hA0 + 32'(i), 1'b0, 1'b1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    step("fifth", 1'b1, 32'h10, 32'hA4, 1'b0, 1'b1);
    check("full_head_pc", 64'(pc_out), 64'h0);
    check("full_head_inst", 64'(inst_out), 64'hA0);

    // Enqueue and dequeue together while full: the head advances and the offer is dropped
    step("full_enq_deq", 1'b1, 32'h14, 32'hA5, 1'b0, 1'b0);
    check("after_full_in_ready", 64'(in_ready), 64'd1);
    while (sb.size() > 0) step("drain_fill", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Streaming with simultaneous enq and deq keeps count at one; pointers wrap repeatedly
    step("stream0", 1'b1, 32'h00, 32'hB0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) step("stream", 1'b1, 32'(i * 4), 32'hB0 + 32'(i), 1'b0, 1'b0);
    check("stream_count", 64'(count), 64'd1);
    step("stream_end", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Flush with concurrent enqueue and dequeue
    for (int i = 0; i < 3; i++) step("pre_flush", 1'b1, 32'h30 + 32'(i * 4), 32'hC0 + 32'(i), 1'b0, 1'b1);
    check("pre_flush_count", 64'(count), 64'd3);
    step("flush", 1'b1, 32'h40, 32'hC8, 1'b1, 1'b0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_inst", 64'(inst_out), 64'h13);
    step("redirect", 1'b1, 32'h80, 32'hD0, 1'b0, 1'b0);
    check("redirect_head_pc", 64'(pc_out), 64'h80);
    step("redirect_drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset mid-operation with a dequeue and an enqueue pending
    step("pre_rst", 1'b1, 32'h90, 32'hE0, 1'b0, 1'b1);
    step("pre_rst", 1'b1, 32'h94, 32'hE1, 1'b0, 1'b1);
    in_valid = 1'b1; pc_in = 32'h98; inst_in = 32'hE2; deq_stall = 1'b0;
    apply_reset("mid_rst");
    in_valid = 1'b0;
    step("post_rst", 1'b1, 32'hA0, 32'hF0, 1'b0, 1'b1);
    step("post_rst", 1'b1, 32'hA4, 32'hF1, 1'b0, 1'b1);
    while (sb.size() > 0) step("post_rst_drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_head("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
